sprite_palette_arbiter: RTL and testbench
=========================================

Name: sprite_palette_arbiter

Overview:
- Per-pixel compositor and palette scheduler for the VGA sprite path.
- Up to NUM_LAYERS sprite ROMs present a 4-bit palette index each pixel. The block picks the highest-priority opaque layer, looks up its colour in a writable per-layer palette RAM, and drives 12-bit RGB to the VGA output stage.
- Also serialises host palette rewrites (palette swaps, power-up colours) into vertical blank so no visible pixel tears.

Parameters:
- NUM_LAYERS, 4, number of sprite requesters; layer 0 has the highest priority.
- IDX_W, 4, palette index width; 2**IDX_W entries per layer.
- TRANSP_IDX, 2, index treated as transparent (magenta key 12'hF0F).

Ports:
- Clk, input, 1, pixel clock.
- Reset_n, input, 1, asynchronous active-low reset.
- pix_valid_i, input, 1, active-video pixel strobe.
- blank_i, input, 1, vertical blank (level).
- layer_vld_i, input, NUM_LAYERS, layer n's sprite covers the current pixel.
- layer_idx_i, input, NUM_LAYERS*IDX_W, packed indices; layer n occupies bits [n*IDX_W +: IDX_W].
- bg_rgb_i, input, 12, background colour {R,G,B}.
- rgb_o, output, 12, composited colour {R,G,B}.
- rgb_vld_o, output, 1, rgb_o is valid.
- hit_o, output, 1, an opaque sprite won this pixel.
- hit_layer_o, output, $clog2(NUM_LAYERS), winning layer (0 when hit_o=0).
- wr_req_i, input, 1, palette write request; held until ack.
- wr_layer_i, input, $clog2(NUM_LAYERS), target layer.
- wr_idx_i, input, IDX_W, target entry.
- wr_rgb_i, input, 12, new colour.
- wr_ack_o, output, 1, one-cycle pulse: write committed.

Behaviour:
- Reset: all outputs 0. Pipeline valids cleared. Write FSM to W_IDLE. Every layer's palette loaded with DEFAULT_PALETTE from the package; reset mid-frame discards in-flight pixels.
- Stage 1 (registered):
  - A layer is opaque when layer_vld_i[n]=1 and its index != TRANSP_IDX.
  - The winner is the lowest-numbered opaque layer. The stage captures the winner, its index, the hit flag, bg_rgb_i and pix_valid_i.
- Stage 2 (registered):
  - hit=1: rgb_o = palette[winner][idx].
  - hit=0: rgb_o = the captured bg_rgb.
  - rgb_vld_o = the stage-1 valid.
- Latency: exactly 2 cycles from pix_valid_i to rgb_vld_o. Full throughput, one pixel per clock, no stalls.
- Inputs with pix_valid_i=0 still propagate: rgb_vld_o=0, and rgb_o/hit_o hold the computed don't-care value.
- Write FSM:
  - W_IDLE: when wr_req_i=1, capture layer/idx/rgb and go to W_PEND.
  - W_PEND: when blank_i=1, write the RAM entry and go to W_ACK. Otherwise stay.
  - W_ACK: wr_ack_o=1 for one cycle, then go to W_IDLE. The requester must drop wr_req_i in the same cycle it sees the ack; a new request is sampled no earlier than the following cycle.
- Boundary conditions:
  - wr_req_i rising during blank: commit on the next cycle, ack one cycle after that (3-cycle ack latency).
  - blank_i falling while in W_PEND: keep waiting.
  - A stage-2 read of the entry being written in the same cycle returns the old value (read-before-write).
  - wr_layer_i >= NUM_LAYERS: no write occurs, but the ack is still issued.
  - All layers transparent or invalid: background output with hit_o=0.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- With the macro defined:
  - Adds output collide_o (1 bit) and output collide_mask_o (NUM_LAYERS).
  - When two or more layers are opaque on a pixel with pix_valid_i=1, collide_o sets and collide_mask_o ORs in those layers. The update is aligned with stage 2.
  - Both are sticky and clear on the rising edge of blank_i. A collision on that same edge is dropped.
  - Both reset to 0.
- Without the macro: no collision ports or logic exist.

Decomposition:
- Package sprite_pkg holds:
  - typedef rgb12_t (packed struct of r,g,b, 4 bits each);
  - typedef pal_idx_t;
  - TRANSP_IDX default;
  - DEFAULT_PALETTE, a 16-entry rgb12_t constant.
- One sub-module, sprite_priority_enc: combinational lowest-index opaque picker that returns the hit flag and the layer number.

Test Plan:
- Priority: layer0 idx 2, layer1 idx 4, layer3 idx 8, all valid -> 2 cycles later hit_o=1, hit_layer_o=1, rgb_o=12'hE33 (default entry 4).
- Transparency: all layers idx 2 or invalid, bg_rgb_i=12'h123 -> rgb_o=12'h123, hit_o=0, rgb_vld_o follows pix_valid_i delayed by 2.
- Blank-gated write: wr_req_i (layer 0, idx 8, 12'h00F) with blank_i=0 for 50 cycles -> no ack and pixels unchanged. Raise blank_i -> ack 2 cycles later; next frame layer0 idx 8 yields 12'h00F.
- Back-to-back streaming: a 640-pixel random run -> every output matches the reference model with 2-cycle latency, no gaps.
- Reset mid-write: Reset_n low while in W_PEND -> no ack, entry keeps its default value, all outputs 0.
- SPRITE_COLLISION_EN: layers 0 and 2 opaque on one pixel -> collide_o=1, collide_mask_o=4'b0101, held until the blank_i rise, then 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite palette arbiter.
// The optional collision detector is enabled by defining SPRITE_COLLISION_EN.
package sprite_pkg;

    localparam int unsigned IDX_W_DEFAULT = 4;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef logic [IDX_W_DEFAULT-1:0] pal_idx_t;

    // Index 2 carries the magenta colour key and is never drawn.
    localparam pal_idx_t TRANSP_IDX_DEFAULT = 4'd2;

    // Power-up colours loaded into every layer's palette.
    localparam rgb12_t DEFAULT_PALETTE [16] = '{
        12'h000, 12'hFFF, 12'hF0F, 12'h888,
        12'hE33, 12'h3E3, 12'h33E, 12'hEE3,
        12'h3EE, 12'hE3E, 12'h840, 12'h048,
        12'h480, 12'h0F0, 12'hF00, 12'h00F
    };

    typedef enum logic [1:0] {
        W_IDLE,
        W_PEND,
        W_ACK
    } wr_state_e;

endpackage

// File: rtl/sprite_palette_arbiter_if.sv
// Pixel, output and palette-write signals of the sprite palette arbiter.
// Collision outputs exist only when SPRITE_COLLISION_EN is defined.
interface sprite_palette_arbiter_if #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned IDX_W      = 4
);
    localparam int unsigned LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                        pix_valid_i;
    logic                        blank_i;
    logic [NUM_LAYERS-1:0]       layer_vld_i;
    logic [NUM_LAYERS*IDX_W-1:0] layer_idx_i;
    logic [11:0]                 bg_rgb_i;

    logic [11:0]                 rgb_o;
    logic                        rgb_vld_o;
    logic                        hit_o;
    logic [LAYER_W-1:0]          hit_layer_o;

    logic                        wr_req_i;
    logic [LAYER_W-1:0]          wr_layer_i;
    logic [IDX_W-1:0]            wr_idx_i;
    logic [11:0]                 wr_rgb_i;
    logic                        wr_ack_o;

`ifdef SPRITE_COLLISION_EN
    logic                        collide_o;
    logic [NUM_LAYERS-1:0]       collide_mask_o;
`endif

    // Video/host side driving the arbiter.
    modport master (
        output pix_valid_i, blank_i, layer_vld_i, layer_idx_i, bg_rgb_i,
        output wr_req_i, wr_layer_i, wr_idx_i, wr_rgb_i,
        input  rgb_o, rgb_vld_o, hit_o, hit_layer_o, wr_ack_o
`ifdef SPRITE_COLLISION_EN
        , input collide_o, collide_mask_o
`endif
    );

    // The arbiter itself.
    modport slave (
        input  pix_valid_i, blank_i, layer_vld_i, layer_idx_i, bg_rgb_i,
        input  wr_req_i, wr_layer_i, wr_idx_i, wr_rgb_i,
        output rgb_o, rgb_vld_o, hit_o, hit_layer_o, wr_ack_o
`ifdef SPRITE_COLLISION_EN
        , output collide_o, collide_mask_o
`endif
    );

endinterface

// File: rtl/sprite_priority_enc.sv
// Combinational picker: lowest-numbered opaque layer wins.
module sprite_priority_enc #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned LAYER_W    = 2
) (
    input  logic [NUM_LAYERS-1:0] opaque_i,
    output logic                  hit_o,
    output logic [LAYER_W-1:0]    layer_o
);

    // Scan from the top so the lowest opaque layer is written last.
    always_comb begin
        hit_o   = 1'b0;
        layer_o = '0;
        for (int n = int'(NUM_LAYERS) - 1; n >= 0; n--) begin
            if (opaque_i[n]) begin
                hit_o   = 1'b1;
                layer_o = LAYER_W'(n);
            end
        end
    end

endmodule

// File: rtl/sprite_palette_arbiter.sv
// Two-stage sprite compositor with per-layer palette RAM and a write
// scheduler that defers host palette updates into vertical blank.
// Define SPRITE_COLLISION_EN to add sticky collision flags.
module sprite_palette_arbiter
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned IDX_W      = 4,
    parameter int unsigned TRANSP_IDX = TRANSP_IDX_DEFAULT
) (
    input logic                     Clk,
    input logic                     Reset_n,
    sprite_palette_arbiter_if.slave bus
);

    localparam int unsigned LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int unsigned DEPTH   = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] TRANSP_KEY = IDX_W'(TRANSP_IDX);

    logic [NUM_LAYERS-1:0] opaque;
    logic                  win_hit;
    logic [LAYER_W-1:0]    win_layer;
    logic [IDX_W-1:0]      win_idx;

    logic                  s1_vld, s1_hit;
    logic [LAYER_W-1:0]    s1_layer;
    logic [IDX_W-1:0]      s1_idx;
    logic [11:0]           s1_bg;

    logic [11:0]           rgb_q;
    logic                  rgb_vld_q, hit_q;
    logic [LAYER_W-1:0]    hit_layer_q;

    rgb12_t                pal_q [NUM_LAYERS][DEPTH];
    rgb12_t                pal_rd;

    wr_state_e             w_state_q;
    logic [LAYER_W-1:0]    w_layer_q;
    logic [IDX_W-1:0]      w_idx_q;
    rgb12_t                w_rgb_q;
    logic                  ack_q;
    logic                  pal_we;

    // Opaque = covered by the sprite and not the colour-key index.
    always_comb begin
        opaque = '0;
        for (int n = 0; n < int'(NUM_LAYERS); n++) begin
            opaque[n] = bus.layer_vld_i[n] &&
                        (bus.layer_idx_i[n*IDX_W +: IDX_W] != TRANSP_KEY);
        end
    end

    sprite_priority_enc #(
        .NUM_LAYERS (NUM_LAYERS),
        .LAYER_W    (LAYER_W)
    ) u_prio (
        .opaque_i (opaque),
        .hit_o    (win_hit),
        .layer_o  (win_layer)
    );

    // Select the winning layer's palette index.
    always_comb begin
        win_idx = '0;
        for (int n = 0; n < int'(NUM_LAYERS); n++) begin
            if (win_hit && (LAYER_W'(n) == win_layer)) begin
                win_idx = bus.layer_idx_i[n*IDX_W +: IDX_W];
            end
        end
    end

    // Stage 1: capture winner, index, background and valid.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_vld   <= 1'b0;
            s1_hit   <= 1'b0;
            s1_layer <= '0;
            s1_idx   <= '0;
            s1_bg    <= '0;
        end else begin
            s1_vld   <= bus.pix_valid_i;
            s1_hit   <= win_hit;
            s1_layer <= win_layer;
            s1_idx   <= win_idx;
            s1_bg    <= bus.bg_rgb_i;
        end
    end

    assign pal_rd = pal_q[s1_layer][s1_idx];

    // Stage 2: palette lookup or background; same-edge writes are not visible here.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q       <= '0;
            rgb_vld_q   <= 1'b0;
            hit_q       <= 1'b0;
            hit_layer_q <= '0;
        end else begin
            rgb_q       <= s1_hit ? pal_rd : s1_bg;
            rgb_vld_q   <= s1_vld;
            hit_q       <= s1_hit;
            hit_layer_q <= s1_layer;
        end
    end

    assign bus.rgb_o       = rgb_q;
    assign bus.rgb_vld_o   = rgb_vld_q;
    assign bus.hit_o       = hit_q;
    assign bus.hit_layer_o = hit_layer_q;

    // Commit only in blank; out-of-range layers are acked but never written.
    assign pal_we = (w_state_q == W_PEND) && bus.blank_i && (32'(w_layer_q) < NUM_LAYERS);

    // Palette RAM, reloaded with the default colours on reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int l = 0; l < int'(NUM_LAYERS); l++) begin
                for (int e = 0; e < int'(DEPTH); e++) begin
                    pal_q[l][e] <= DEFAULT_PALETTE[e % 16];
                end
            end
        end else if (pal_we) begin
            pal_q[w_layer_q][w_idx_q] <= w_rgb_q;
        end
    end

    // Write scheduler; a request still high during its own ack is not re-sampled.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            w_state_q <= W_IDLE;
            w_layer_q <= '0;
            w_idx_q   <= '0;
            w_rgb_q   <= '0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (w_state_q)
                W_IDLE: begin
                    if (bus.wr_req_i && !ack_q) begin
                        w_layer_q <= bus.wr_layer_i;
                        w_idx_q   <= bus.wr_idx_i;
                        w_rgb_q   <= bus.wr_rgb_i;
                        w_state_q <= W_PEND;
                    end
                end
                W_PEND: begin
                    if (bus.blank_i) begin
                        w_state_q <= W_ACK;
                    end
                end
                W_ACK: begin
                    ack_q     <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign bus.wr_ack_o = ack_q;

`ifdef SPRITE_COLLISION_EN
    logic                  multi;
    logic                  s1_coll;
    logic [NUM_LAYERS-1:0] s1_mask;
    logic                  blank_q;
    logic                  collide_q;
    logic [NUM_LAYERS-1:0] collide_mask_q;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign multi = |(opaque & (opaque - NUM_LAYERS'(1)));

    // Collision stage 1, aligned with the pixel pipeline.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_coll <= 1'b0;
            s1_mask <= '0;
            blank_q <= 1'b0;
        end else begin
            s1_coll <= bus.pix_valid_i && multi;
            s1_mask <= (bus.pix_valid_i && multi) ? opaque : '0;
            blank_q <= bus.blank_i;
        end
    end

    // Sticky flags; the blank rise clears and wins over a coincident collision.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            collide_q      <= 1'b0;
            collide_mask_q <= '0;
        end else if (bus.blank_i && !blank_q) begin
            collide_q      <= 1'b0;
            collide_mask_q <= '0;
        end else if (s1_coll) begin
            collide_q      <= 1'b1;
            collide_mask_q <= collide_mask_q | s1_mask;
        end
    end

    assign bus.collide_o      = collide_q;
    assign bus.collide_mask_o = collide_mask_q;
`endif

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Self-checking bench for sprite_palette_arbiter (collision checks when
// SPRITE_COLLISION_EN is defined).
module tb_sprite_palette_arbiter;

    localparam int unsigned NL = 4;
    localparam int unsigned IW = 4;
    localparam int unsigned LW = 2;

    localparam logic [11:0] DEF_PAL [16] = '{
        12'h000, 12'hFFF, 12'hF0F, 12'h888,
        12'hE33, 12'h3E3, 12'h33E, 12'hEE3,
        12'h3EE, 12'hE3E, 12'h840, 12'h048,
        12'h480, 12'h0F0, 12'hF00, 12'h00F
    };

    typedef struct {
        logic [11:0]   rgb;
        logic          vld;
        logic          hit;
        logic [LW-1:0] layer;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n;
    int   total = 0;
    int   bad   = 0;
    logic [11:0] ref_pal [NL][16];
    exp_t q [$];

    always #5 Clk = ~Clk;

    sprite_palette_arbiter_if #(.NUM_LAYERS(NL), .IDX_W(IW)) bus ();

    sprite_palette_arbiter #(
        .NUM_LAYERS (NL),
        .IDX_W      (IW),
        .TRANSP_IDX (2)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_model();
        for (int l = 0; l < int'(NL); l++)
            for (int e = 0; e < 16; e++) ref_pal[l][e] = DEF_PAL[e];
    endtask

    task automatic set_pixel(input logic pv, input logic [NL-1:0] vld,
                             input logic [NL*IW-1:0] idx, input logic [11:0] bg);
        bus.pix_valid_i = pv;
        bus.layer_vld_i = vld;
        bus.layer_idx_i = idx;
        bus.bg_rgb_i    = bg;
    endtask

    // Reference: first visible non-key layer in priority order, else background.
    function automatic exp_t model(input logic pv, input logic [NL-1:0] vld,
                                   input logic [NL*IW-1:0] idx, input logic [11:0] bg);
        exp_t e;
        e.rgb = bg; e.vld = pv; e.hit = 1'b0; e.layer = '0;
        for (int n = 0; n < int'(NL); n++) begin
            logic [IW-1:0] ix;
            ix = idx[n*IW +: IW];
            if (vld[n] && ix != 4'd2) begin
                e.hit = 1'b1; e.layer = LW'(n); e.rgb = ref_pal[n][ix];
                break;
            end
        end
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_rgb"}, bus.rgb_o, 0);
        check({tag, "_vld"}, bus.rgb_vld_o, 0);
        check({tag, "_hit"}, bus.hit_o, 0);
        check({tag, "_layer"}, bus.hit_layer_o, 0);
        check({tag, "_ack"}, bus.wr_ack_o, 0);
`ifdef SPRITE_COLLISION_EN
        check({tag, "_coll"}, bus.collide_o, 0);
        check({tag, "_mask"}, bus.collide_mask_o, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic [NL-1:0]    rv;
        logic [NL*IW-1:0] ri;

        Reset_n = 1'b0;
        set_pixel(0, '0, '0, '0);
        bus.blank_i = 0; bus.wr_req_i = 0; bus.wr_layer_i = '0;
        bus.wr_idx_i = '0; bus.wr_rgb_i = '0;
        reset_model();
        repeat (3) tick();
        check_zero("reset");
        Reset_n = 1'b1;
        tick();

        // Priority: layer0 keyed, layer1 idx 4 wins.
        set_pixel(1, 4'b1111, {4'h8, 4'h2, 4'h4, 4'h2}, 12'h777);
        tick(); tick();
        check("prio_vld", bus.rgb_vld_o, 1);
        check("prio_hit", bus.hit_o, 1);
        check("prio_layer", bus.hit_layer_o, 1);
        check("prio_rgb", bus.rgb_o, 12'hE33);

        // Transparency and valid latency.
        set_pixel(0, 4'b0111, {4'h5, 4'h2, 4'h2, 4'h2}, 12'h123);
        tick(); tick();
        check("transp_rgb", bus.rgb_o, 12'h123);
        check("transp_hit", bus.hit_o, 0);
        check("transp_layer", bus.hit_layer_o, 0);
        check("transp_vld0", bus.rgb_vld_o, 0);
        bus.pix_valid_i = 1; tick();
        check("lat_d1", bus.rgb_vld_o, 0);
        bus.pix_valid_i = 0; tick();
        check("lat_d2", bus.rgb_vld_o, 1);
        check("lat_rgb", bus.rgb_o, 12'h123);
        tick();
        check("lat_d3", bus.rgb_vld_o, 0);

        // Write held off while not in blank.
        set_pixel(1, 4'b0001, 16'h0008, 12'h000);
        bus.wr_req_i = 1; bus.wr_layer_i = 0; bus.wr_idx_i = 8; bus.wr_rgb_i = 12'h00F;
        repeat (50) begin
            tick();
            check("gated_ack", bus.wr_ack_o, 0);
        end
        check("gated_pix", bus.rgb_o, ref_pal[0][8]);
        bus.blank_i = 1;
        tick();
        check("blank_ack_d1", bus.wr_ack_o, 0);
        check("rbw_old", bus.rgb_o, ref_pal[0][8]);
        ref_pal[0][8] = 12'h00F;
        tick();
        check("blank_ack_d2", bus.wr_ack_o, 1);
        check("rbw_new", bus.rgb_o, ref_pal[0][8]);
        bus.wr_req_i = 0;
        repeat (5) begin
            tick();
            check("no_resample", bus.wr_ack_o, 0);
        end

        // Request rising inside blank: 3-cycle ack; pixel reads old then new.
        set_pixel(1, 4'b0010, 16'h0050, 12'h000);
        bus.wr_req_i = 1; bus.wr_layer_i = 1; bus.wr_idx_i = 5; bus.wr_rgb_i = 12'hABC;
        tick();
        check("rise_ack1", bus.wr_ack_o, 0);
        tick();
        check("rise_ack2", bus.wr_ack_o, 0);
        check("rise_rbw_old", bus.rgb_o, ref_pal[1][5]);
        ref_pal[1][5] = 12'hABC;
        tick();
        check("rise_ack3", bus.wr_ack_o, 1);
        check("rise_rbw_new", bus.rgb_o, ref_pal[1][5]);
        bus.wr_req_i = 0;
        tick();
        check("rise_ack_drop", bus.wr_ack_o, 0);
        bus.blank_i = 0;

        // Back-to-back random stream against the model.
        for (int i = 0; i < 642; i++) begin
            if (i < 640) begin
                rv = NL'($urandom);
                ri = 16'($urandom);
                for (int n = 0; n < int'(NL); n++)
                    if ($urandom_range(0, 3) == 0) ri[n*IW +: IW] = 4'd2;
                set_pixel(1, rv, ri, 12'($urandom));
            end else begin
                set_pixel(0, '0, '0, 12'h000);
            end
            q.push_back(model(bus.pix_valid_i, bus.layer_vld_i, bus.layer_idx_i, bus.bg_rgb_i));
            tick();
            if (q.size() == 2) begin
                e = q.pop_front();
                check("stream_vld", bus.rgb_vld_o, e.vld);
                check("stream_hit", bus.hit_o, e.hit);
                check("stream_layer", bus.hit_layer_o, e.layer);
                check("stream_rgb", bus.rgb_o, e.rgb);
            end
        end

        // Reset while a write waits for blank.
        set_pixel(1, 4'b0001, 16'h0001, 12'h000);
        bus.wr_req_i = 1; bus.wr_layer_i = 2; bus.wr_idx_i = 7; bus.wr_rgb_i = 12'h555;
        repeat (3) tick();
        #2 Reset_n = 1'b0;
        #1 check_zero("rst_mid");
        bus.wr_req_i = 0;
        set_pixel(0, '0, '0, 12'h000);
        tick();
        check_zero("rst_hold");
        Reset_n = 1'b1;
        reset_model();
        bus.blank_i = 1;
        repeat (5) begin
            tick();
            check("rst_no_ack", bus.wr_ack_o, 0);
        end
        bus.blank_i = 0;
        set_pixel(1, 4'b0100, 16'h0700, 12'h000);
        tick(); tick();
        check("rst_pal_hit", bus.hit_o, 1);
        check("rst_pal_layer", bus.hit_layer_o, 2);
        check("rst_pal_rgb", bus.rgb_o, ref_pal[2][7]);

`ifdef SPRITE_COLLISION_EN
        set_pixel(0, '0, '0, 12'h000);
        tick(); tick();
        check("coll_idle", bus.collide_o, 0);
        set_pixel(1, 4'b0101, {4'h0, 4'h3, 4'h2, 4'h1}, 12'h000);
        tick();
        set_pixel(0, '0, '0, 12'h000);
        tick();
        check("coll_set", bus.collide_o, 1);
        check("coll_mask", bus.collide_mask_o, 4'b0101);
        repeat (4) tick();
        check("coll_sticky", bus.collide_o, 1);
        check("coll_sticky_mask", bus.collide_mask_o, 4'b0101);
        bus.blank_i = 1;
        tick();
        check("coll_clr", bus.collide_o, 0);
        check("coll_clr_mask", bus.collide_mask_o, 0);
        bus.blank_i = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
